mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width. It implements MULT, MULTU, DIV and DIVU, plus MTHI/MTLO writes, for the pipelined MIPS datapath. It sits beside the ALU in the execute stage. The pipeline stalls on busy and reads hi/lo for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO (even, >= 4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not to be overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset, sampled on rising clk
start  input  1  single-cycle request to begin an operation
op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 11x reserved
a  input  WIDTH  operand rs (multiplicand or dividend)
b  input  WIDTH  operand rt (multiplier or divisor)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO write data
busy  output  1  operation in progress
done  output  1  one-cycle pulse when HI/LO are updated by an operation
div_by_zero  output  1  sticky flag for last op; set by DIV/DIVU with b==0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0. Applies mid-operation: the operation is abandoned, no done pulse, and HI/LO are cleared.
- FSM states: IDLE, RUN, FIN.
- IDLE: start=1 with a valid op latches a, b and op, loads the counter with WIDTH and moves to RUN. start with a reserved op is ignored.
- RUN: one iteration per cycle, a radix-2 shift-add multiply or restoring divide on magnitudes. The counter decrements each cycle; when it reaches 0 the FSM moves to FIN.
- FIN: applies sign correction and writes HI/LO. done=1 for exactly this cycle, then the FSM returns to IDLE.
- busy=1 in RUN and FIN.
- Latency: start sampled at edge k; busy=1 after edge k; new HI/LO and done=1 visible after edge k+WIDTH+1. busy and done both drop after edge k+WIDTH+2.
- Back-to-back: start is accepted in the IDLE cycle immediately after FIN.
- start while busy: ignored, no queueing.
- Multiply results:
  - {HI,LO} = full 2*WIDTH product.
  - MULT treats operands as two's complement; MULTU treats them as unsigned.
- Divide results:
  - LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - DIVU is unsigned.
  - Signed overflow (min-negative / -1): LO = min-negative, HI = 0, div_by_zero=0.
- Divide by zero: takes full latency; HI = a, LO = all ones, div_by_zero=1.
- div_by_zero is cleared when any new operation is accepted.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we load wdata into HI/LO at the next edge.
  - While busy, they are ignored.
  - start and a write in the same IDLE cycle: start wins, the write is dropped.
  - hi_we and lo_we together load both registers with wdata.
- Operand a/b changes after start are irrelevant, because operands are latched.

Optional Feature:
Macro MULDIV_MADD_EN.
- Defined: op 100 (MADD, signed) and 101 (MADDU) compute {HI,LO} <= {HI,LO} + product. HI/LO are sampled at FIN, the sum is modulo 2^(2*WIDTH), and latency is the same as MULT.
- Not defined: ops 100/101 are treated as reserved; start is ignored, and there are no accumulator adder resources.

Test Plan:
1. WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done after 33 cycles, hi=0xFFFFFFFE, lo=0x00000001, busy high for exactly 34 cycles.
2. MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU a=0x64 b=0 -> div_by_zero=1, hi=0x00000064, lo=0xFFFFFFFF. Next, DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
4. MULTU 5*6, re-pulse start with DIVU 9/3 at cycle 5 -> ignored, final hi=0 lo=30. In the IDLE cycle after done, DIVU 9/3 -> lo=3, hi=0.
5. MULTU 5*6, drive reset=0 for one cycle at cycle 10 -> busy=0, hi=lo=0, no done pulse. Then lo_we=1 with wdata=0x1234 -> lo=0x1234 next cycle. lo_we during a subsequent busy period -> lo unchanged.
6. With MULDIV_MADD_EN: MTHI 0, MTLO 10, MADD a=2 b=3 -> lo=16, hi=0. MADD a=-1 b=20 -> lo=0xFFFFFFFC, hi=0xFFFFFFFF. Without the macro: MADD start -> busy stays 0.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_MADD_EN to enable the MADD/MADDU accumulate operations.
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dbz_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   operand_q;
  logic [WIDTH-1:0]   a_q;
  logic               is_div_q;
  logic               neg_q;
  logic               rem_neg_q;
  logic               b_zero_q;
`ifdef MULDIV_MADD_EN
  logic               madd_q;
`endif

  logic               op_valid;
  logic               accept;
  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MULDIV_MADD_EN
  assign op_valid = (op <= 3'd5);
`else
  assign op_valid = ~op[2];
`endif

  assign accept    = (state_q == IDLE) && start && op_valid;
  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   trial;
  logic               fits;

  assign mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, operand_q} : '0);
  assign shifted = {acc_q, q_q[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, operand_q});
  assign trial   = shifted[WIDTH-1:0] - operand_q;

  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] mul_result;
  logic [2*WIDTH-1:0] result;

  assign prod_mag = {acc_q, q_q};
  assign prod_res = neg_q ? -prod_mag : prod_mag;
  assign quot     = neg_q ? -q_q : q_q;
  assign rem      = rem_neg_q ? -acc_q : acc_q;

`ifdef MULDIV_MADD_EN
  assign mul_result = madd_q ? ({hi_q, lo_q} + prod_res) : prod_res;
`else
  assign mul_result = prod_res;
`endif

  // Divide by zero reports the raw dividend in HI and all ones in LO.
  always_comb begin
    result = mul_result;
    if (is_div_q) begin
      if (b_zero_q) result = {a_q, {WIDTH{1'b1}}};
      else          result = {rem, quot};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
      acc_q     <= '0;
      q_q       <= '0;
      operand_q <= '0;
      a_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
`ifdef MULDIV_MADD_EN
      madd_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q     <= CNT_W'(WIDTH);
            dbz_q     <= 1'b0;
            acc_q     <= '0;
            q_q       <= op[1] ? a_mag : b_mag;
            operand_q <= op[1] ? b_mag : a_mag;
            a_q       <= a;
            is_div_q  <= op[1];
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            b_zero_q  <= (b == '0);
`ifdef MULDIV_MADD_EN
            madd_q    <= op[2];
`endif
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        RUN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (is_div_q) begin
              acc_q <= fits ? trial : shifted[WIDTH-1:0];
              q_q   <= {q_q[WIDTH-2:0], fits};
            end else begin
              acc_q <= mul_sum[WIDTH:1];
              q_q   <= {mul_sum[0], q_q[WIDTH-1:1]};
            end
          end else begin
            hi_q  <= result[2*WIDTH-1:WIDTH];
            lo_q  <= result[WIDTH-1:0];
            dbz_q <= is_div_q & b_zero_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_mips_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int vectors = 0;
  int errors  = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_dbz = 1'b0;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain wide arithmetic on the architectural HI/LO.
  task automatic model_apply(input logic [2:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb);
    longint       sp, sq, sr;
    logic [63:0]  up;
    sp = longint'($signed(ma)) * longint'($signed(mb));
    up = 64'(ma) * 64'(mb);
    m_dbz = 1'b0;
    case (mop)
      3'd0: {m_hi, m_lo} = sp;
      3'd1: {m_hi, m_lo} = up;
      3'd2: begin
        if (mb == '0) begin
          m_hi = ma; m_lo = '1; m_dbz = 1'b1;
        end else begin
          sq = longint'($signed(ma)) / longint'($signed(mb));
          sr = longint'($signed(ma)) % longint'($signed(mb));
          m_lo = sq[W-1:0];
          m_hi = sr[W-1:0];
        end
      end
      3'd3: begin
        if (mb == '0) begin
          m_hi = ma; m_lo = '1; m_dbz = 1'b1;
        end else begin
          m_lo = ma / mb;
          m_hi = ma % mb;
        end
      end
      3'd4: {m_hi, m_lo} = {m_hi, m_lo} + 64'(sp);
      3'd5: {m_hi, m_lo} = {m_hi, m_lo} + up;
      default: ;
    endcase
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issues one operation and waits (bounded) for done; operands are scrambled after start.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output int busy_n,
                       output logic [W-1:0] rhi, output logic [W-1:0] rlo, output logic rdbz,
                       output logic busy_after, output logic done_after);
    start = 1'b1; op = o; a = x; b = y;
    step();
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    busy_n = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 200) begin
      step();
      lat++;
      if (busy === 1'b1) busy_n++;
    end
    rhi = hi; rlo = lo; rdbz = div_by_zero;
    step();
    busy_after = busy;
    done_after = done;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    vectors++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz: got %b expected 0", div_by_zero); end
    vectors++; if (hi !== '0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
    vectors++; if (lo !== '0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_directed();
    int lat, bn;
    logic [W-1:0] rh, rl;
    logic rd, ba, da;
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bn, rh, rl, rd, ba, da);
    vectors++; if (lat !== 33) begin errors++; $display("[TB] FAIL multu_latency: got %0d expected 33", lat); end
    vectors++; if (bn !== 34) begin errors++; $display("[TB] FAIL multu_busy_cycles: got %0d expected 34", bn); end
    vectors++; if (rh !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL multu_hi: got %h expected fffffffe", rh); end
    vectors++; if (rl !== 32'h0000_0001) begin errors++; $display("[TB] FAIL multu_lo: got %h expected 00000001", rl); end
    vectors++; if (ba !== 1'b0) begin errors++; $display("[TB] FAIL busy_drop: got %b expected 0", ba); end
    vectors++; if (da !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse: got %b expected 0", da); end

    do_op(3'd0, 32'hFFFF_FFFD, 32'd7, lat, bn, rh, rl, rd, ba, da);
    vectors++; if (rh !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", rh); end
    vectors++; if (rl !== 32'hFFFF_FFEB) begin errors++; $display("[TB] FAIL mult_lo: got %h expected ffffffeb", rl); end

    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat, bn, rh, rl, rd, ba, da);
    vectors++; if (rl !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_lo: got %h expected fffffffd", rl); end
    vectors++; if (rh !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_hi: got %h expected ffffffff", rh); end

    do_op(3'd3, 32'h64, 32'd0, lat, bn, rh, rl, rd, ba, da);
    vectors++; if (lat !== 33) begin errors++; $display("[TB] FAIL dbz_latency: got %0d expected 33", lat); end
    vectors++; if (rd !== 1'b1) begin errors++; $display("[TB] FAIL dbz_flag: got %b expected 1", rd); end
    vectors++; if (rh !== 32'h64) begin errors++; $display("[TB] FAIL dbz_hi: got %h expected 00000064", rh); end
    vectors++; if (rl !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL dbz_lo: got %h expected ffffffff", rl); end
    vectors++; if (div_by_zero !== 1'b1) begin errors++; $display("[TB] FAIL dbz_sticky: got %b expected 1", div_by_zero); end

    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn, rh, rl, rd, ba, da);
    vectors++; if (rl !== 32'h8000_0000) begin errors++; $display("[TB] FAIL ovf_lo: got %h expected 80000000", rl); end
    vectors++; if (rh !== 32'h0) begin errors++; $display("[TB] FAIL ovf_hi: got %h expected 0", rh); end
    vectors++; if (rd !== 1'b0) begin errors++; $display("[TB] FAIL ovf_dbz: got %b expected 0", rd); end
  endtask

  task automatic test_start_while_busy();
    int lat, bn;
    logic [W-1:0] rh, rl;
    logic rd, ba, da;
    do_op(3'd3, 32'd100, 32'd0, lat, bn, rh, rl, rd, ba, da);
    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd6;
    step();
    start = 1'b0;
    vectors++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL dbz_clear_on_accept: got %b expected 0", div_by_zero); end
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == 5) begin start = 1'b1; op = 3'd3; a = 32'd9; b = 32'd3; end
      step();
      start = 1'b0;
      lat++;
    end
    vectors++; if (lat !== 33) begin errors++; $display("[TB] FAIL ignore_start_latency: got %0d expected 33", lat); end
    vectors++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL ignore_start_hi: got %h expected 0", hi); end
    vectors++; if (lo !== 32'd30) begin errors++; $display("[TB] FAIL ignore_start_lo: got %h expected 1e", lo); end
    step();
    do_op(3'd3, 32'd9, 32'd3, lat, bn, rh, rl, rd, ba, da);
    vectors++; if (lat !== 33) begin errors++; $display("[TB] FAIL back_to_back_latency: got %0d expected 33", lat); end
    vectors++; if (rl !== 32'd3) begin errors++; $display("[TB] FAIL back_to_back_lo: got %h expected 3", rl); end
    vectors++; if (rh !== 32'd0) begin errors++; $display("[TB] FAIL back_to_back_hi: got %h expected 0", rh); end
  endtask

  task automatic test_reset_mid_op_and_writes();
    int n;
    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd6;
    step();
    start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
    vectors++; if (hi !== '0) begin errors++; $display("[TB] FAIL midreset_hi: got %h expected 0", hi); end
    vectors++; if (lo !== '0) begin errors++; $display("[TB] FAIL midreset_lo: got %h expected 0", lo); end
    n = 0;
    repeat (40) begin
      step();
      if (done === 1'b1) n++;
    end
    vectors++; if (n !== 0) begin errors++; $display("[TB] FAIL midreset_no_done: got %0d pulses expected 0", n); end

    lo_we = 1'b1; wdata = 32'h1234;
    step();
    lo_we = 1'b0;
    vectors++; if (lo !== 32'h1234) begin errors++; $display("[TB] FAIL mtlo: got %h expected 00001234", lo); end
    vectors++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL mtlo_hi_untouched: got %h expected 0", hi); end

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hABCD_0123;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
    vectors++; if (hi !== 32'hABCD_0123) begin errors++; $display("[TB] FAIL both_we_hi: got %h expected abcd0123", hi); end
    vectors++; if (lo !== 32'hABCD_0123) begin errors++; $display("[TB] FAIL both_we_lo: got %h expected abcd0123", lo); end

    start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3; lo_we = 1'b1; wdata = 32'h5555;
    step();
    start = 1'b0; lo_we = 1'b0;
    vectors++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL start_wins_busy: got %b expected 1", busy); end
    vectors++; if (lo !== 32'hABCD_0123) begin errors++; $display("[TB] FAIL start_wins_lo: got %h expected abcd0123", lo); end
    step();
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h7777;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
    vectors++; if (lo !== 32'hABCD_0123) begin errors++; $display("[TB] FAIL busy_we_lo: got %h expected abcd0123", lo); end
    vectors++; if (hi !== 32'hABCD_0123) begin errors++; $display("[TB] FAIL busy_we_hi: got %h expected abcd0123", hi); end
    n = 0;
    while (done !== 1'b1 && n < 200) begin step(); n++; end
    vectors++; if (lo !== 32'd6) begin errors++; $display("[TB] FAIL after_busy_we_lo: got %h expected 6", lo); end
    vectors++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL after_busy_we_hi: got %h expected 0", hi); end
    step();
  endtask

  task automatic test_reserved_and_madd();
    int lat, bn;
    logic [W-1:0] rh, rl;
    logic rd, ba, da;
    logic [2:0] rsv [$];
    rsv = '{3'd6, 3'd7};
`ifndef MULDIV_MADD_EN
    rsv.push_back(3'd4);
    rsv.push_back(3'd5);
`endif
    foreach (rsv[i]) begin
      start = 1'b1; op = rsv[i]; a = 32'd2; b = 32'd3;
      step();
      start = 1'b0;
      vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reserved_busy op=%0d: got %b expected 0", rsv[i], busy); end
      step();
      vectors++; if (lo !== 32'd6) begin errors++; $display("[TB] FAIL reserved_lo op=%0d: got %h expected 6", rsv[i], lo); end
    end
`ifdef MULDIV_MADD_EN
    hi_we = 1'b1; wdata = 32'd0;
    step();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'd10;
    step();
    lo_we = 1'b0;
    do_op(3'd4, 32'd2, 32'd3, lat, bn, rh, rl, rd, ba, da);
    vectors++; if (rl !== 32'd16) begin errors++; $display("[TB] FAIL madd_lo: got %h expected 10", rl); end
    vectors++; if (rh !== 32'd0) begin errors++; $display("[TB] FAIL madd_hi: got %h expected 0", rh); end
    vectors++; if (lat !== 33) begin errors++; $display("[TB] FAIL madd_latency: got %0d expected 33", lat); end
    do_op(3'd4, 32'hFFFF_FFFF, 32'd20, lat, bn, rh, rl, rd, ba, da);
    vectors++; if (rl !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL madd_neg_lo: got %h expected fffffffc", rl); end
    vectors++; if (rh !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL madd_neg_hi: got %h expected ffffffff", rh); end
`endif
  endtask

  task automatic test_random();
    int lat, bn;
    logic [W-1:0] rh, rl, x, y;
    logic rd, ba, da;
    logic [2:0] o;
    m_hi = $urandom; m_lo = $urandom;
    hi_we = 1'b1; wdata = m_hi;
    step();
    hi_we = 1'b0; lo_we = 1'b1; wdata = m_lo;
    step();
    lo_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
`ifdef MULDIV_MADD_EN
      o = 3'($urandom_range(0, 5));
`else
      o = 3'($urandom_range(0, 3));
`endif
      x = pick();
      y = pick();
      if (i % 8 == 7) y = '1;
      do_op(o, x, y, lat, bn, rh, rl, rd, ba, da);
      model_apply(o, x, y);
      vectors++; if (rh !== m_hi || rl !== m_lo) begin errors++; $display("[TB] FAIL random_hilo op=%0d a=%h b=%h: got %h_%h expected %h_%h", o, x, y, rh, rl, m_hi, m_lo); end
      vectors++; if (rd !== m_dbz) begin errors++; $display("[TB] FAIL random_dbz op=%0d a=%h b=%h: got %b expected %b", o, x, y, rd, m_dbz); end
      vectors++; if (lat !== 33 || ba !== 1'b0) begin errors++; $display("[TB] FAIL random_timing op=%0d: got lat=%0d busy_after=%b expected lat=33 busy_after=0", o, lat, ba); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_mid_op_and_writes();
    test_reserved_and_madd();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
